// File: rtl/zint_mc.sv
// Multi-channel Z80 IM2 interrupt controller: fixed-priority pending latches,
// generated vectors, optional per-source pulse expiry and vdos drop policy.
module zint_mc #(
    parameter int              NSRC        = 4,
    parameter logic [7:0]      VECT_BASE   = 8'hFF,
    parameter int              VECT_STEP   = 2,
    parameter logic [NSRC-1:0] EXPIRE_MASK = NSRC'(4'b0001),
    parameter logic [NSRC-1:0] DROP_MASK   = NSRC'(4'b0011),
    parameter int              PULSE_LEN   = 32
) (
    input  logic            clk,
    input  logic            res,
    input  logic            zpos,
    input  logic            wait_n,
    input  logic            vdos,
    input  logic            intack,
    input  logic [NSRC-1:0] int_start,
    input  logic [NSRC-1:0] intmask,
    input  logic [NSRC-1:0] pend_clr,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] ovf,
    output logic [7:0]      im2vect,
    output logic [2:0]      ack_src,
    output logic            ack_stb,
    output logic            int_n
);

    localparam logic [7:0] PLEN    = 8'(PULSE_LEN);
    localparam logic [7:0] PLEN_M1 = 8'(PULSE_LEN - 1);

    function automatic logic [7:0] vect_of(input int idx);
        int v;
        v = int'(VECT_BASE) - VECT_STEP * idx;
        return v[7:0];
    endfunction

    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] r_ovf;
    logic [7:0]      r_im2vect;
    logic [2:0]      r_ack_src;
    logic            r_ack_stb;
    logic            r_intack;
    logic            r_wait;

    logic [NSRC-1:0] w_acc;
    logic [NSRC-1:0] w_exp_done;
    logic [NSRC-1:0] w_pend_nxt;
    logic [NSRC-1:0] w_ovf_nxt;
    logic [2:0]      w_win;
    logic            w_any;
    logic            w_ack;

    assign w_any = |r_pending;
    assign w_ack = intack && !r_intack && w_any;
    assign w_acc = int_start & ~({NSRC{vdos}} & DROP_MASK);

    // Descending scan so the lowest pending index is the last one written.
    always_comb begin
        w_win = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (r_pending[i]) w_win = 3'(i);
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_pend_nxt = r_pending;
        w_ovf_nxt  = r_ovf;
        for (int i = 0; i < NSRC; i++) begin
            if (!intmask[i]) begin
                w_pend_nxt[i] = 1'b0;
                w_ovf_nxt[i]  = 1'b0;
            end else if (w_acc[i]) begin
                w_pend_nxt[i] = 1'b1;
                if (r_pending[i]) w_ovf_nxt[i] = 1'b1;
            end else if (pend_clr[i]) begin
                w_pend_nxt[i] = 1'b0;
                w_ovf_nxt[i]  = 1'b0;
            end else if (w_ack && (w_win == 3'(i))) begin
                w_pend_nxt[i] = 1'b0;
            end else if (w_exp_done[i]) begin
                w_pend_nxt[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        if (EXPIRE_MASK[g]) begin : g_exp
            logic [7:0] r_cnt;
            logic       w_inc;

            // Stalls (wait, vdos) freeze the count so the pulse is stretched, never cut.
            assign w_inc = r_pending[g] && zpos && !r_wait && !vdos && (r_cnt < PLEN);
            assign w_exp_done[g] = w_inc && (r_cnt == PLEN_M1) && !w_acc[g];

            // NOTE: sequential state uses non-blocking assignments only.
            always_ff @(posedge clk or posedge res) begin
                if (res)            r_cnt <= 8'd0;
                else if (w_acc[g])  r_cnt <= 8'd0;
                else if (w_inc)     r_cnt <= r_cnt + 8'd1;
            end
        end else begin : g_hold
            assign w_exp_done[g] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_pending <= '0;
            r_ovf     <= '0;
            r_im2vect <= vect_of(0);
            r_ack_src <= 3'd0;
            r_ack_stb <= 1'b0;
            r_intack  <= 1'b0;
            r_wait    <= 1'b0;
        end else begin
            r_pending <= w_pend_nxt;
            r_ovf     <= w_ovf_nxt;
            r_intack  <= intack;
            r_wait    <= !wait_n;
            r_ack_stb <= w_ack || (|w_exp_done);
            if (w_ack) begin
                r_ack_src <= w_win;
                r_im2vect <= vect_of(int'(w_win));
            end
        end
    end

    assign pending = r_pending;
    assign ovf     = r_ovf;
    assign im2vect = r_im2vect;
    assign ack_src = r_ack_src;
    assign ack_stb = r_ack_stb;
    assign int_n   = !(w_any && !vdos);

endmodule

// File: tb/tb_zint_mc.sv
// Directed self-checking bench for zint_mc with default parameters.
module tb_zint_mc;

    logic       clk = 1'b0;
    logic       res;
    logic       zpos;
    logic       wait_n;
    logic       vdos;
    logic       intack;
    logic [3:0] int_start;
    logic [3:0] intmask;
    logic [3:0] pend_clr;
    logic [3:0] pending;
    logic [3:0] ovf;
    logic [7:0] im2vect;
    logic [2:0] ack_src;
    logic       ack_stb;
    logic       int_n;

    int n_tests = 0;
    int n_fail  = 0;
    int n_low;
    int n_stb;

    zint_mc dut (
        .clk       (clk),
        .res       (res),
        .zpos      (zpos),
        .wait_n    (wait_n),
        .vdos      (vdos),
        .intack    (intack),
        .int_start (int_start),
        .intmask   (intmask),
        .pend_clr  (pend_clr),
        .pending   (pending),
        .ovf       (ovf),
        .im2vect   (im2vect),
        .ack_src   (ack_src),
        .ack_stb   (ack_stb),
        .int_n     (int_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Fire int_start for one cycle, then count int_n-low and ack_stb samples.
    task automatic pulse_count(input logic [3:0] src, input int n, input int wait_at);
        int_start = src;
        @(negedge clk);
        int_start = 4'b0000;
        n_low = 0;
        n_stb = 0;
        for (int k = 0; k < n; k++) begin
            if (!int_n) n_low++;
            if (ack_stb) n_stb++;
            if (wait_at >= 0 && k == wait_at) wait_n = 1'b0;
            if (wait_at >= 0 && k == wait_at + 10) wait_n = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        res       = 1'b1;
        zpos      = 1'b1;
        wait_n    = 1'b1;
        vdos      = 1'b0;
        intack    = 1'b0;
        int_start = 4'b0000;
        intmask   = 4'hF;
        pend_clr  = 4'b0000;
        #2;
        check("rst_pending", pending, 4'b0000);
        check("rst_ovf", ovf, 4'b0000);
        check("rst_int_n", int_n, 1'b1);
        check("rst_im2vect", im2vect, 8'hFF);
        check("rst_ack_src", ack_src, 3'd0);
        check("rst_ack_stb", ack_stb, 1'b0);
        @(negedge clk);
        res = 1'b0;
        @(negedge clk);

        // Expiring frame pulse: 32 clocks low, one strobe at completion.
        pulse_count(4'b0001, 40, -1);
        check("exp_low_clks", n_low, 32);
        check("exp_stb_count", n_stb, 1);
        check("exp_pending", pending, 4'b0000);

        // Two held sources, priority ack order.
        int_start = 4'b0110;
        @(negedge clk);
        int_start = 4'b0000;
        check("two_pending", pending, 4'b0110);
        check("two_int_n", int_n, 1'b0);
        intack = 1'b1;
        @(negedge clk);
        check("ack1_vect", im2vect, 8'hFD);
        check("ack1_src", ack_src, 3'd1);
        check("ack1_pending", pending, 4'b0100);
        check("ack1_int_n", int_n, 1'b0);
        check("ack1_stb", ack_stb, 1'b1);
        @(negedge clk);
        check("hold_pending", pending, 4'b0100);
        check("hold_stb", ack_stb, 1'b0);
        intack = 1'b0;
        @(negedge clk);
        intack = 1'b1;
        @(negedge clk);
        check("ack2_vect", im2vect, 8'hFB);
        check("ack2_src", ack_src, 3'd2);
        check("ack2_pending", pending, 4'b0000);
        check("ack2_int_n", int_n, 1'b1);
        intack = 1'b0;
        @(negedge clk);

        // vdos: source 1 dropped, source 3 latched but masked at the pin.
        vdos = 1'b1;
        int_start = 4'b1010;
        @(negedge clk);
        int_start = 4'b0000;
        check("vdos_pending", pending, 4'b1000);
        check("vdos_ovf", ovf, 4'b0000);
        check("vdos_int_n", int_n, 1'b1);
        vdos = 1'b0;
        #1;
        check("vdos_off_int_n", int_n, 1'b0);
        @(negedge clk);
        intack = 1'b1;
        @(negedge clk);
        check("ack3_vect", im2vect, 8'hF9);
        check("ack3_src", ack_src, 3'd3);
        check("ack3_pending", pending, 4'b0000);
        intack = 1'b0;
        @(negedge clk);

        // Ack with nothing pending changes nothing.
        intack = 1'b1;
        @(negedge clk);
        check("idle_ack_vect", im2vect, 8'hF9);
        check("idle_ack_src", ack_src, 3'd3);
        check("idle_ack_stb", ack_stb, 1'b0);
        intack = 1'b0;
        @(negedge clk);

        // Overflow, software clear, start coincident with ack.
        int_start = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        int_start = 4'b0000;
        check("ovf_set", ovf, 4'b0100);
        check("ovf_pending", pending, 4'b0100);
        pend_clr = 4'b0100;
        @(negedge clk);
        pend_clr = 4'b0000;
        check("clr_pending", pending, 4'b0000);
        check("clr_ovf", ovf, 4'b0000);
        int_start = 4'b0100;
        @(negedge clk);
        intack = 1'b1;
        @(negedge clk);
        int_start = 4'b0000;
        check("coinc_pending", pending, 4'b0100);
        check("coinc_vect", im2vect, 8'hFB);
        check("coinc_stb", ack_stb, 1'b1);
        intack = 1'b0;
        pend_clr = 4'b0100;
        @(negedge clk);
        pend_clr = 4'b0000;
        check("coinc_cleanup", pending, 4'b0000);
        @(negedge clk);

        // wait_n low for 10 ticks stretches the pulse to 42 clocks.
        pulse_count(4'b0001, 60, 5);
        check("wait_low_clks", n_low, 42);
        check("wait_stb_count", n_stb, 1);

        // Masking a source mid-pulse releases int_n on the next edge.
        int_start = 4'b0001;
        @(negedge clk);
        int_start = 4'b0000;
        repeat (5) @(negedge clk);
        intmask = 4'hE;
        #1;
        check("mask_before_edge", int_n, 1'b0);
        @(negedge clk);
        check("mask_int_n", int_n, 1'b1);
        check("mask_pending", pending, 4'b0000);
        intmask = 4'hF;
        @(negedge clk);

        // Asynchronous reset in the middle of a pulse.
        int_start = 4'b0001;
        @(negedge clk);
        int_start = 4'b0000;
        repeat (10) @(negedge clk);
        #2;
        res = 1'b1;
        #1;
        check("arst_pending", pending, 4'b0000);
        check("arst_int_n", int_n, 1'b1);
        check("arst_im2vect", im2vect, 8'hFF);
        check("arst_ack_src", ack_src, 3'd0);
        @(negedge clk);
        res = 1'b0;
        @(negedge clk);
        pulse_count(4'b0001, 40, -1);
        check("post_rst_low_clks", n_low, 32);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
